// File: rtl/uart_tx_sched.sv
// Shared UART transmitter: round-robin arbiter over four byte requesters
// feeding an 8N1/8N2 serializer that is paced only by the external bit tick.
module uart_tx_sched #(
  parameter int STOP_BITS = 1
) (
  input  logic        clk_50mhz,
  input  logic        rst_n,
  input  logic        tx_tick,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic        tx,
  output logic        busy,
  output logic [1:0]  grant_id
);
  localparam int NUM_REQ = 4;

  typedef enum logic [2:0] {IDLE, ARMED, START, DATA, STOP} state_t;

  state_t                      state, state_n;
  logic [NUM_REQ-1:0][7:0]     lane_data;
  logic [7:0]                  shift, shift_n;
  logic [2:0]                  bit_cnt, bit_cnt_n;
  logic                        stop_cnt, stop_cnt_n;
  logic                        tx_n, busy_n;
  logic [1:0]                  last_grant, winner;
  logic                        stop_last, window, accept;

  assign lane_data = req_data;
  assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
  // A new byte can be taken while idle, or on the tick that closes the last
  // stop bit so the next start bit follows with no idle gap.
  assign window    = (state == IDLE) || (state == STOP && tx_tick && stop_last);
  assign accept    = rst_n && window && (|req_valid);
  assign req_ready = accept ? (4'b0001 << winner) : 4'b0000;

  // Round-robin pick: scan from last_grant+1 upward; the nearest valid wins.
  always_comb begin
    winner = last_grant;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[last_grant + 2'(k)]) winner = last_grant + 2'(k);
    end
  end

  // Next-state, shifter and line-level decode; everything advances on tx_tick.
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    tx_n       = tx;
    busy_n     = busy;
    case (state)
      IDLE: begin
        if (accept) begin
          shift_n = lane_data[winner];
          busy_n  = 1'b1;
          if (tx_tick) begin
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = ARMED;
          end
        end
      end
      ARMED: begin
        if (tx_tick) begin
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (tx_tick) begin
          state_n   = DATA;
          tx_n      = shift[0];
          bit_cnt_n = 3'd0;
        end
      end
      DATA: begin
        if (tx_tick) begin
          if (bit_cnt == 3'd7) begin
            state_n    = STOP;
            tx_n       = 1'b1;
            stop_cnt_n = 1'b0;
          end else begin
            shift_n   = {1'b0, shift[7:1]};
            tx_n      = shift[1];
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (tx_tick) begin
          if (!stop_last) begin
            stop_cnt_n = 1'b1;
          end else if (accept) begin
            shift_n = lane_data[winner];
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight byte.
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift      <= 8'h00;
      bit_cnt    <= 3'd0;
      stop_cnt   <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      grant_id   <= 2'd0;
      last_grant <= 2'd3;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      tx       <= tx_n;
      busy     <= busy_n;
      if (accept) begin
        grant_id   <= winner;
        last_grant <= winner;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: two instances (1 and 2 stop bits) with their own
// requester handshakes, a frame-level reference model and a tx-line decoder.
module tb_uart_tx_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_tick = 1'b0;
  logic [3:0]  v   [2];
  logic [31:0] d   [2];
  logic [3:0]  rdy [2];
  logic        txs [2];
  logic        bsy [2];
  logic [1:0]  gid [2];
  logic [3:0]  seen [2];

  int tests = 0;
  int fails = 0;
  bit done = 1'b0;
  bit timeout = 1'b0;
  int tph = 0;

  // reference model: ticks left until the accept window, last grant, frame bits
  int          rem  [2] = '{0, 0};
  int          last [2] = '{3, 3};
  int          mg   [2] = '{0, 0};
  logic [10:0] fb   [2];
  int          q    [2][$];
  // tx-line decoder
  int          ds [2] = '{0, 0};
  int          dc [2] = '{0, 0};
  logic [7:0]  db [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    uart_tx_sched #(.STOP_BITS(g + 1)) u_dut (
      .clk_50mhz(clk), .rst_n(rst_n), .tx_tick(tx_tick),
      .req_valid(v[g]), .req_data(d[g]), .req_ready(rdy[g]),
      .tx(txs[g]), .busy(bsy[g]), .grant_id(gid[g]));
  end

  function automatic int rr(int lg, logic [3:0] vv);
    for (int k = 1; k <= 4; k++) begin
      if (vv[(lg + k) % 4]) return (lg + k) % 4;
    end
    return lg;
  endfunction

  task automatic check(string nm, int g, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s inst%0d t=%0t actual=%0h expected=%0h", nm, g, $time, act, exp);
    end
  endtask

  // Compare outputs against the model, decode the line, then advance the model
  // with the inputs that the coming posedge will sample.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin : per_inst
      int sb, win, er, i, e;
      bit wok;
      logic [7:0] by;
      sb  = g + 1;
      win = rr(last[g], v[g]);
      wok = (rem[g] == 0) || (rem[g] == 1 && tx_tick);
      er  = (rst_n && wok && v[g] != 4'd0) ? (1 << win) : 0;
      check("req_ready", g, int'(rdy[g]), er);
      check("busy", g, int'(bsy[g]), int'(rem[g] > 0));
      i = 9 + sb - rem[g];
      check("tx", g, int'(txs[g]), (rem[g] == 0 || i < 0) ? 1 : int'(fb[g][i]));
      check("grant_id", g, int'(gid[g]), mg[g]);
      seen[g] = rdy[g];

      if (!rst_n) begin
        ds[g] = 0;
      end else if (tx_tick) begin
        case (ds[g])
          0: if (!txs[g]) begin ds[g] = 1; dc[g] = 0; end
          1: begin
            db[g][dc[g]] = txs[g];
            dc[g]++;
            if (dc[g] == 8) begin ds[g] = 2; dc[g] = 0; end
          end
          default: begin
            check("stop_bit", g, int'(txs[g]), 1);
            dc[g]++;
            if (dc[g] == sb) begin
              ds[g] = 0;
              tests++;
              if (q[g].size() == 0) begin
                fails++;
                $display("FAIL frame_unexpected inst%0d t=%0t actual=%0h expected=none", g, $time, db[g]);
              end else begin
                e = q[g].pop_front();
                check("frame_byte", g, int'(db[g]), e % 256);
                check("frame_id", g, int'(gid[g]), e / 256);
              end
            end
          end
        endcase
      end

      if (!rst_n) begin
        rem[g] = 0; last[g] = 3; mg[g] = 0;
        q[g].delete();
      end else begin
        if (tx_tick && rem[g] > 0) rem[g]--;
        if (wok && v[g] != 4'd0) begin
          by = d[g][8*win +: 8];
          q[g].push_back(win * 256 + int'(by));
          last[g] = win;
          mg[g]   = win;
          fb[g]   = {2'b11, by, 1'b0};
          rem[g]  = tx_tick ? 9 + sb : 10 + sb;
        end
      end
    end
    if (done) begin
      for (int g = 0; g < 2; g++) begin
        check("queue_empty", g, q[g].size(), 0);
        check("decoder_idle", g, ds[g], 0);
      end
      check("no_timeout", 0, int'(timeout), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  // one cycle: retire handshaken requests, advance the tick every 4 cycles
  task automatic step();
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) v[g] = v[g] & ~seen[g];
    tx_tick = (tph == 3);
    tph = (tph + 1) % 4;
  endtask

  task automatic post(int i, logic [7:0] b);
    for (int g = 0; g < 2; g++) begin
      if (!v[g][i]) begin
        v[g][i] = 1'b1;
        d[g][8*i +: 8] = b;
      end
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (c < 3000 && !(rem[0] == 0 && rem[1] == 0 && v[0] == 4'd0 && v[1] == 4'd0)) begin
      step();
      c++;
    end
    if (c >= 3000) timeout = 1'b1;
  endtask

  task automatic align();
    step();
    while (!tx_tick) step();
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin v[g] = 4'd0; d[g] = 32'd0; end
    repeat (3) step();
    rst_n = 1'b1;
    // single byte through the armed path
    step();
    post(1, 8'hA5);
    drain();
    // acceptance coincident with a tick
    align();
    post(2, 8'h3C);
    drain();
    // all four requesters continuously valid
    for (int c = 0; c < 260; c++) begin
      for (int i = 0; i < 4; i++) post(i, 8'($urandom));
      step();
    end
    drain();
    // two zero bytes back-to-back from one requester
    post(0, 8'h00);
    step();
    post(0, 8'h00);
    drain();
    // reset during the fourth data bit with requester 0 still pending
    align();
    post(0, 8'h96);
    step();
    post(0, 8'h5A);
    repeat (18) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drain();
    // requester 2 withdraws after two cycles during a frame
    post(1, 8'h77);
    repeat (6) step();
    post(2, 8'hEE);
    step();
    step();
    for (int g = 0; g < 2; g++) v[g][2] = 1'b0;
    drain();
    // random traffic with occasional withdrawal
    for (int c = 0; c < 1500; c++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(9) == 0) post(i, 8'($urandom));
        else if ($urandom_range(49) == 0) for (int g = 0; g < 2; g++) v[g][i] = 1'b0;
      end
    end
    drain();
    done = 1'b1;
    repeat (4) step();
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Shared UART transmit controller.
- Arbitrates round-robin among four byte requesters and serializes the granted byte as an 8-data-bit, no-parity frame with a configurable number of stop bits.
- Paced entirely by the one-cycle bit-rate tick from the baud tick generator; contains no rate divider of its own.
- Sits between on-chip byte producers (status reporter, debug console, command responder, spare) and the single UART TX pin.

## Interface
Parameters:
- STOP_BITS, 1, stop bits per frame. Legal values are 1 or 2.

Ports:
- clk_50mhz  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- tx_tick  in  1  bit-rate strobe, one cycle wide. At least 2 cycles between strobes.
- req_valid  in  4  requester i has a byte pending.
- req_data  in  32  requester i byte in bits [8i+7:8i].
- req_ready  out  4  one-hot acceptance strobe, combinational.
- tx  out  1  serial output, registered, idle high.
- busy  out  1  frame loaded or in progress, registered.
- grant_id  out  2  index of the requester whose byte is loaded or in flight, registered.

## Operation
States:
- IDLE: no frame loaded.
- ARMED: byte loaded, waiting for the first tick.
- START: start bit on the line.
- DATA: 8 data bits, LSB first, counted by a 3-bit bit counter.
- STOP: STOP_BITS stop bits, counted by a stop counter.

Arbitration:
- A 2-bit pointer last_grant resets to 3, so requester 0 has first priority.
- Search order is last_grant+1, +2, +3, +4, all mod 4.
- The winner is the first index with req_valid set.

Accept window (the block can accept a byte when either holds):
- State is IDLE.
- State is STOP, tx_tick is high, and this tick ends the final stop bit.

Acceptance:
- In the accept window, req_ready[winner]=1 and all other ready bits are 0. Outside the window req_ready=0.
- In that cycle the block captures req_data of the winner into the shift register, sets grant_id and last_grant to the winner, and sets busy to 1.
- The requester holds req_valid and data stable until it sees ready. Valid may deassert at any time before acceptance; that request is then simply skipped.

Transitions:
- Acceptance in IDLE with tx_tick=0 goes to ARMED.
- Acceptance in IDLE with tx_tick=1 goes to START; tx becomes 0.
- ARMED on tick goes to START; tx becomes 0.
- START on tick goes to DATA; tx becomes shift[0].
- DATA on tick:
  - After the 8th bit period, go to STOP; tx becomes 1.
  - Otherwise shift right; tx becomes the next bit.
- STOP on tick:
  - Before the final stop bit ends: count and stay in STOP.
  - At the end of the final stop bit, with an acceptance: go directly to START; tx becomes 0. This gives back-to-back frames with no idle gap.
  - At the end of the final stop bit, with no request: go to IDLE; busy becomes 0; tx stays 1.

Other rules:
- tx_tick is ignored in IDLE when no request is present.
- grant_id holds its value after the frame ends.
- Reset is synchronous and can occur mid-frame:
  - The next edge forces IDLE, tx=1, busy=0, grant_id=0, last_grant=3, and clears the counters.
  - The in-flight byte is dropped and never retransmitted.
  - Unacknowledged requesters stay pending.
  - req_ready is 0 while rst_n=0.

## Timing
Reset values: tx=1, busy=0, grant_id=0, req_ready=0.

Latency, for a tick at cycle T:
- The tx change it causes is visible at T+1.
- A start-bit tick at T produces tx low for cycles T+1 through the next tick cycle.

Frame length:
- Exactly 9+STOP_BITS tick intervals: 1 start + 8 data + STOP_BITS stop.
- With STOP_BITS=1, back-to-back frames start every 10 tick intervals.

Accept-to-start latency:
- In IDLE: 0 if the tick coincides with acceptance, otherwise until the next tick.

busy rises the cycle after acceptance.

## Test plan
All scenarios use a tick every 4 cycles.
1. Single byte: requester 1 sends 0xA5.
   - ready[1] pulses once; grant_id=1.
   - tx per interval is 0,1,0,1,0,0,1,0,1,1.
   - busy falls after the stop interval.
2. Round robin: all four valid continuously, distinct bytes.
   - Grant order is 0,1,2,3,0.
   - Frames are back-to-back, 10 intervals each, with no idle high gap beyond stop bits.
3. Tick coincident with acceptance in IDLE: tx falls the next cycle and no ARMED interval is spent.
4. Reset pulse mid-DATA, after 3 data bits:
   - tx=1, busy=0, grant_id=0 on the next cycle.
   - The still-pending requester 0 is granted afresh after release.
5. STOP_BITS=2 with 0x00 sent twice back-to-back: frame is 0, eight 0s, 1, 1, then the next start bit immediately.
6. Valid withdrawn: requester 2 valid for 2 cycles during a frame, then drops. It is never granted, and ready[2] never pulses.
